// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - select sequencer and sampler for a 16:1 channel mux
//
// On an accepted start the block walks the mux select s through every channel
// enabled in mask. It holds each select for DWELL cycles and samples the returned
// mux output f on the last dwell cycle. Each sample is emitted as a tagged serial
// bit and is also gathered into a 16-bit word.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous active-high reset
//   start     in   1   scan request, accepted only while busy is low
//   mask      in   16  channel enables, captured on an accepted start
//   f         in   1   mux output for the current select
//   s         out  4   mux select
//   bit_out   out  1   sampled value of f
//   ch_out    out  4   channel that bit_out belongs to
//   bit_valid out  1   one-cycle pulse qualifying bit_out/ch_out
//   word_out  out  16  assembled scan word, bit k = sample of channel k
//   busy      out  1   high while scanning and in the done cycle
//   done      out  1   one-cycle pulse at the end of a pass

module mux_scan_sequencer #(
    parameter int DWELL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mask,
    input  logic        f,
    output logic [3:0]  s,
    output logic        bit_out,
    output logic [3:0]  ch_out,
    output logic        bit_valid,
    output logic [15:0] word_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  cnt;
    logic [15:0] mask_r;
    logic [4:0]  first_ch;   // {found, channel}
    logic [4:0]  next_ch;    // {found, channel}
    logic        last_dwell;

    // Lowest enabled channel at or above lo. The MSB flags whether one exists.
    // lo is 5 bits wide so that "above 15" (16) can be expressed. This stops
    // the search from wrapping back to channel 0 within a pass.
    function automatic logic [4:0] lowest_from(input logic [15:0] m, input logic [4:0] lo);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i] && (5'(i) >= lo)) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

    assign first_ch   = lowest_from(mask, 5'd0);
    assign next_ch    = lowest_from(mask_r, {1'b0, s} + 5'd1);
    assign last_dwell = (cnt == LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = first_ch[4] ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (last_dwell && !next_ch[4]) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SCAN:    busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath. The select is left on the last channel when the pass ends,
    // and it stays there through IDLE until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= 4'd0;
            cnt       <= 8'd0;
            mask_r    <= 16'd0;
            bit_out   <= 1'b0;
            ch_out    <= 4'd0;
            bit_valid <= 1'b0;
            word_out  <= 16'd0;
        end else begin
            bit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_r   <= mask;
                        word_out <= 16'd0;
                        cnt      <= 8'd0;
                        if (first_ch[4]) begin
                            s <= first_ch[3:0];
                        end
                    end
                end
                SCAN: begin
                    if (last_dwell) begin
                        bit_out     <= f;
                        ch_out      <= s;
                        word_out[s] <= f;
                        bit_valid   <= 1'b1;
                        cnt         <= 8'd0;
                        if (next_ch[4]) begin
                            s <= next_ch[3:0];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - scoreboard testbench for mux_scan_sequencer
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_v     [3];
    logic [15:0] mask_v      [3];
    logic [15:0] mux_in      [3];
    logic        f_v         [3];
    logic [3:0]  s_v         [3];
    logic        bit_out_v   [3];
    logic [3:0]  ch_out_v    [3];
    logic        bit_valid_v [3];
    logic [15:0] word_v      [3];
    logic        busy_v      [3];
    logic        done_v      [3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          inst;
        bit          is_done;
        int          cyc;
        logic [3:0]  ch;
        logic        b;
        logic [15:0] word;
    } ev_t;

    ev_t exp_q[$];

    // Instance 0: DWELL=1, instance 1: DWELL=2, instance 2: DWELL=4
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        assign f_v[g] = mux_in[g][s_v[g]];
        mux_scan_sequencer #(.DWELL(g == 0 ? 1 : (g == 1 ? 2 : 4))) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_v[g]),
            .mask      (mask_v[g]),
            .f         (f_v[g]),
            .s         (s_v[g]),
            .bit_out   (bit_out_v[g]),
            .ch_out    (ch_out_v[g]),
            .bit_valid (bit_valid_v[g]),
            .word_out  (word_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected events for a pass started in cycle c0. Only the first
    // nmax samples are queued; if the pass is truncated, no done event is queued.
    task automatic issue(input int k, input logic [15:0] m, input logic [15:0] v,
                         input int c0, input int nmax);
        int  d;
        int  j;
        ev_t e;
        d = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
        j = 0;
        for (int ch = 0; ch < 16; ch++) begin
            if (m[ch]) begin
                if (j < nmax) begin
                    e.inst = k; e.is_done = 1'b0; e.cyc = c0 + (j + 1) * d + 1;
                    e.ch = 4'(ch); e.b = v[ch]; e.word = 16'd0;
                    exp_q.push_back(e);
                end
                j++;
            end
        end
        if (j <= nmax) begin
            e.inst = k; e.is_done = 1'b1; e.cyc = c0 + j * d + 1;
            e.ch = 4'd0; e.b = 1'b0; e.word = v & m;
            exp_q.push_back(e);
        end
    endtask

    task automatic pop_check(input int k, input bit is_done);
        ev_t e;
        if (exp_q.size() == 0) begin
            check(is_done ? "unexpected_done" : "unexpected_bit_valid", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", {31'd0, is_done}, {31'd0, e.is_done});
        check("event_inst", k, e.inst);
        check("event_cycle", cyc, e.cyc);
        if (is_done) begin
            check("word_at_done", {16'd0, word_v[k]}, {16'd0, e.word});
            check("busy_at_done", {31'd0, busy_v[k]}, 32'd1);
        end else begin
            check("ch_out", {28'd0, ch_out_v[k]}, {28'd0, e.ch});
            check("bit_out", {31'd0, bit_out_v[k]}, {31'd0, e.b});
        end
    endtask

    // Monitor: samples away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (bit_valid_v[k] === 1'b1) pop_check(k, 1'b0);
            if (done_v[k] === 1'b1)      pop_check(k, 1'b1);
        end
    end

    task automatic wait_idle(input int k, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_v[k] !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle_in_budget", {31'd0, n < budget}, 32'd1);
    endtask

    task automatic check_zero(input int k, input string tag);
        check({tag, "_s"},         {28'd0, s_v[k]},         32'd0);
        check({tag, "_bit_out"},   {31'd0, bit_out_v[k]},   32'd0);
        check({tag, "_ch_out"},    {28'd0, ch_out_v[k]},    32'd0);
        check({tag, "_bit_valid"}, {31'd0, bit_valid_v[k]}, 32'd0);
        check({tag, "_word_out"},  {16'd0, word_v[k]},      32'd0);
        check({tag, "_busy"},      {31'd0, busy_v[k]},      32'd0);
        check({tag, "_done"},      {31'd0, done_v[k]},      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0; mask_v[k] = 16'd0; mux_in[k] = 16'd0;
        end
        tick(); tick();
        for (int k = 0; k < 3; k++) check_zero(k, "reset");
        rst = 1'b0;
        tick();

        // Full scan, DWELL=1; the mask input changes while busy
        mux_in[0] = 16'hA5C3; mask_v[0] = 16'hFFFF; start_v[0] = 1'b1; c0 = cyc;
        issue(0, 16'hFFFF, 16'hA5C3, c0, 16);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) begin start_v[0] = 1'b0; mask_v[0] = 16'h0000; end
            check("t1_s", {28'd0, s_v[0]}, i);
        end
        wait_idle(0, 100);
        tick(); tick(); tick();
        check("t1_word_hold", {16'd0, word_v[0]}, 32'h0000A5C3);

        // DWELL=2, only the end channels are enabled
        mux_in[1] = 16'h8001; mask_v[1] = 16'h8001; start_v[1] = 1'b1; c0 = cyc;
        issue(1, 16'h8001, 16'h8001, c0, 16);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) start_v[1] = 1'b0;
            check("t2_s", {28'd0, s_v[1]}, (i < 2) ? 32'd0 : 32'd15);
        end
        wait_idle(1, 100);

        // Empty mask: straight to DONE; the word from test 1 is cleared
        mask_v[0] = 16'h0000; start_v[0] = 1'b1; c0 = cyc;
        issue(0, 16'h0000, 16'h0000, c0, 16);
        tick();
        start_v[0] = 1'b0;
        check("t3_busy_c1", {31'd0, busy_v[0]}, 32'd1);
        check("t3_done_c1", {31'd0, done_v[0]}, 32'd1);
        check("t3_word_cleared", {16'd0, word_v[0]}, 32'd0);
        tick();
        check("t3_busy_c2", {31'd0, busy_v[0]}, 32'd0);
        wait_idle(0, 20);

        // start held high: a second pass is accepted in the cycle after done
        mux_in[0] = 16'h0050; mask_v[0] = 16'h00F0; start_v[0] = 1'b1; c0 = cyc;
        issue(0, 16'h00F0, 16'h0050, c0, 16);
        issue(0, 16'h00F0, 16'h0050, c0 + 6, 16);
        repeat (7) tick();
        start_v[0] = 1'b0;
        wait_idle(0, 100);

        // Reset in the middle of cycle 6 of a full pass
        mux_in[0] = 16'h3C96; mask_v[0] = 16'hFFFF; start_v[0] = 1'b1; c0 = cyc;
        issue(0, 16'hFFFF, 16'h3C96, c0, 4);
        tick();
        start_v[0] = 1'b0;
        repeat (5) tick();
        #1 rst = 1'b1;
        #1 check_zero(0, "midreset");
        tick(); tick();
        rst = 1'b0;
        check("t5_partial_consumed", exp_q.size(), 32'd0);
        tick();
        start_v[0] = 1'b1; c0 = cyc;
        issue(0, 16'hFFFF, 16'h3C96, c0, 16);
        tick();
        start_v[0] = 1'b0;
        wait_idle(0, 100);

        // DWELL=4, bit 9 toggles during dwell; only the last dwell cycle counts
        for (int run = 0; run < 2; run++) begin
            mux_in[2] = 16'h0000; mask_v[2] = 16'h0200; start_v[2] = 1'b1; c0 = cyc;
            issue(2, 16'h0200, (run == 0) ? 16'h0000 : 16'h0200, c0, 16);
            for (int i = 1; i <= 4; i++) begin
                tick();
                if (i == 1) start_v[2] = 1'b0;
                mux_in[2] = (((i + run) % 2) == 1) ? 16'h0200 : 16'h0000;
            end
            wait_idle(2, 50);
        end

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
